csa_accumulator: RTL

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator_pkg.sv | 18 +
 rtl/csa_accumulator_csa4to2_row.sv | 46 ++++
 rtl/csa_accumulator.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/csa_accumulator_pkg.sv
// csa_accumulator_pkg
//   Shared definitions for the carry-save packet accumulator:
//   - default parameter values (data width, accumulator width, beat-counter width)
//   - the control FSM state encoding
package csa_accumulator_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

endpackage

// File: rtl/csa_accumulator_csa4to2_row.sv
// csa4to2_row
//   Purely combinational, W-bit wide 4:2 compressor row built from two
//   cascaded rows of full adders. sum + carry == a + b + c + d (mod 2^W).
//   Both outputs are already weight-aligned (carry is shifted left by one).
// Ports
//   a, b, c, d : input  [W-1:0] four operands
//   sum        : output [W-1:0] sum vector
//   carry      : output [W-1:0] carry vector (bit 0 always 0)
module csa4to2_row #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  // First-row partial sum and its shifted carry; the majority of the top bit
  // would fall off the word, so only W-1 majorities are formed per row.
  logic [W-1:0] t;
  logic [W-1:0] m1_sh;

  assign m1_sh[0] = 1'b0;
  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_row1
      assign t[gi] = a[gi] ^ b[gi] ^ c[gi];
    end

    for (genvar gi = 0; gi < W - 1; gi++) begin : g_row1_carry
      assign m1_sh[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_row2
      assign sum[gi] = t[gi] ^ d[gi] ^ m1_sh[gi];
    end

    for (genvar gi = 0; gi < W - 1; gi++) begin : g_row2_carry
      assign carry[gi+1] = (t[gi] & d[gi]) | (t[gi] & m1_sh[gi]) | (d[gi] & m1_sh[gi]);
    end
  endgenerate

endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator
//   Accumulates a packet of carry-save beats (sum/carry vectors from an
//   upstream compressor tree) without any carry-propagate adder in the
//   per-beat path. The final beat (in_last) triggers a single resolve cycle
//   that adds the two accumulator halves, after which the result is offered
//   on a valid/ready output together with a saturating beat count.
//
//   Optional feature: define CSA_ACC_BIAS_EN to add port in_bias, which is
//   sampled on the first beat of each packet as the accumulator start value.
//
// Ports
//   clk       : input            clock, rising edge
//   reset     : input            synchronous active-high reset
//   in_valid  : input            beat valid
//   in_ready  : output           beat accepted this cycle (IDLE/ACCUM)
//   in_sum    : input  [DATA_W]  sum vector (two's complement)
//   in_carry  : input  [DATA_W]  carry vector (two's complement, aligned)
//   in_last   : input            final beat of packet
//   out_valid : output           result available (OUTPUT state)
//   out_ready : input            downstream accepts result
//   out_data  : output [ACC_W]   resolved packet sum, modulo 2^ACC_W
//   out_count : output [CNT_W]   beats in packet, saturating
//   in_bias   : input  [ACC_W]   (CSA_ACC_BIAS_EN only) packet start value
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic [DATA_W-1:0] in_carry,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count
`ifdef CSA_ACC_BIAS_EN
  ,
  input  logic [ACC_W-1:0]  in_bias
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_reg, state_next;

  logic [ACC_W-1:0] acc_s_reg;
  logic [ACC_W-1:0] acc_c_reg;
  logic [CNT_W-1:0] count_reg;
  logic [ACC_W-1:0] out_data_reg;
  logic [CNT_W-1:0] out_count_reg;

  logic             beat;
  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] carry_ext;
  logic [ACC_W-1:0] init_s;
  logic [ACC_W-1:0] red_in_s;
  logic [ACC_W-1:0] red_in_c;
  logic [ACC_W-1:0] red_s;
  logic [ACC_W-1:0] red_c;

  assign sum_ext   = ACC_W'($signed(in_sum));
  assign carry_ext = ACC_W'($signed(in_carry));

`ifdef CSA_ACC_BIAS_EN
  assign init_s = in_bias;
`else
  assign init_s = '0;
`endif

  // The first beat of a packet reduces against the start value rather than
  // the stored accumulator, so bias is picked up exactly once per packet.
  assign red_in_s = (state_reg == IDLE) ? init_s : acc_s_reg;
  assign red_in_c = (state_reg == IDLE) ? '0     : acc_c_reg;

  csa4to2_row #(
    .W(ACC_W)
  ) u_row (
    .a    (sum_ext),
    .b    (carry_ext),
    .c    (red_in_s),
    .d    (red_in_c),
    .sum  (red_s),
    .carry(red_c)
  );

  assign beat = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = in_last ? RESOLVE : ACCUM;
        end
      end
      RESOLVE: begin
        state_next = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      acc_s_reg     <= '0;
      acc_c_reg     <= '0;
      count_reg     <= '0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (beat) begin
        acc_s_reg <= red_s;
        acc_c_reg <= red_c;
        if (state_reg == IDLE) begin
          count_reg <= CNT_W'(1);
        end else if (count_reg != CNT_MAX) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end

      if (state_reg == RESOLVE) begin
        out_data_reg  <= acc_s_reg + acc_c_reg;
        out_count_reg <= count_reg;
      end

      if ((state_reg == OUTPUT) && out_ready) begin
        acc_s_reg <= '0;
        acc_c_reg <= '0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;

endmodule
